// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer placing two requesters onto one shared
// combinational ALU, with registered operands and a held response handshake.
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [OPW-1:0]   r0_op,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [OPW-1:0]   r1_op,
  output logic             rsp_valid,
  output logic             rsp_id,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry_out,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [OPW-1:0] LAST_LEGAL_OP = OPW'(5);

  state_t           state, state_nxt;
  logic             prio;
  logic             lat_id;
  logic [WIDTH-1:0] lat_a, lat_b;
  logic [OPW-1:0]   lat_op;
  logic             grant_any, grant_id, accept, op_legal;

  // Winner selection: a lone requester always wins; a tie goes to prio.
  always_comb begin
    grant_any = r0_valid | r1_valid;
    grant_id  = (r0_valid & r1_valid) ? prio : r1_valid;
    r0_ready  = (state == IDLE) & grant_any & ~grant_id;
    r1_ready  = (state == IDLE) & grant_any & grant_id;
    accept    = (state == IDLE) & grant_any;
    op_legal  = (lat_op <= LAST_LEGAL_OP);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request latch and fairness pointer; the ALU sees these registers directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio   <= 1'b0;
      lat_id <= 1'b0;
      lat_a  <= '0;
      lat_b  <= '0;
      lat_op <= '0;
    end else if (accept) begin
      prio   <= ~grant_id;
      lat_id <= grant_id;
      lat_a  <= grant_id ? r1_a  : r0_a;
      lat_b  <= grant_id ? r1_b  : r0_b;
      lat_op <= grant_id ? r1_op : r0_op;
    end
  end

  // Illegal opcodes report a fixed zero result instead of whatever the ALU drives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id <= lat_id;
      if (op_legal) begin
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry_out;
        rsp_zero   <= alu_zero;
        rsp_err    <= 1'b0;
      end else begin
        rsp_result <= '0;
        rsp_carry  <= 1'b0;
        rsp_zero   <= 1'b1;
        rsp_err    <= 1'b1;
      end
    end
  end

  always_comb begin
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
    alu_a     = lat_a;
    alu_b     = lat_b;
    alu_op    = lat_op;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU stub, arbitration and
// response model, directed scenarios plus randomized transactions.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0_valid, r1_valid, r0_ready, r1_ready;
  logic [3:0] r0_a, r0_b, r1_a, r1_b;
  logic [2:0] r0_op, r1_op;
  logic       rsp_valid, rsp_id, rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_carry, rsp_zero, rsp_err, busy;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       alu_carry_out, alu_zero;

  int vectors = 0;
  int miscompares = 0;
  logic model_prio = 1'b0;

  alu_arbiter #(.WIDTH(4), .OPW(3)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // ALU stand-in; illegal opcodes drive junk the arbiter must ignore.
  always_comb begin
    alu_result    = 4'h0;
    alu_carry_out = 1'b0;
    alu_zero      = 1'b0;
    case (alu_op)
      3'd0: {alu_carry_out, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: {alu_carry_out, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = ~alu_a;
      default: begin alu_result = 4'hA; alu_carry_out = 1'b1; end
    endcase
    if (alu_op <= 3'd5) alu_zero = (alu_result == 4'h0);
  end

  // Expected {carry, zero, err, result} from plain arithmetic.
  function automatic logic [6:0] exp_rsp(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    int s;
    logic [3:0] r;
    logic c;
    c = 1'b0;
    r = 4'h0;
    s = 0;
    case (op)
      3'd0: begin s = int'(a) + int'(b); r = 4'(s % 16); c = (s > 15); end
      3'd1: begin s = int'(a) - int'(b) + 16; r = 4'(s % 16); c = (a >= b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = 4'(15 - int'(a));
      default: return 7'b0110000;
    endcase
    return {c, (r == 4'h0), 1'b0, r};
  endfunction

  task automatic idle_inputs();
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_a = 4'h0; r0_b = 4'h0; r0_op = 3'd0;
    r1_a = 4'h0; r1_b = 4'h0; r1_op = 3'd0;
  endtask

  // Stimulus only: one request from requester id, response consumed at once.
  task automatic single_txn(input logic id, input logic [3:0] a, input logic [3:0] b,
                            input logic [2:0] op, output logic [1:0] rdy,
                            output logic [8:0] rsp);
    rsp_ready = 1'b1;
    if (id) begin r1_valid = 1'b1; r1_a = a; r1_b = b; r1_op = op; end
    else    begin r0_valid = 1'b1; r0_a = a; r0_b = b; r0_op = op; end
    #1 rdy = {r1_ready, r0_ready};
    @(negedge clk);
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
    rsp = {rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_err, rsp_result};
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    vectors++;
    if ({rsp_valid, busy, rsp_id, rsp_carry, rsp_zero, rsp_err, rsp_result} !== 10'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_rsp got %b exp 0",
               {rsp_valid, busy, rsp_id, rsp_carry, rsp_zero, rsp_err, rsp_result});
    end
    vectors++;
    if ({alu_a, alu_b, alu_op} !== 11'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_alu got %h exp 0", {alu_a, alu_b, alu_op});
    end
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    vectors++;
    if ({r1_ready, r0_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL reset_grant got %b exp 01", {r1_ready, r0_ready});
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_prio = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_add();
    logic [1:0] rdy;
    logic [8:0] rsp;
    single_txn(1'b0, 4'd5, 4'd3, 3'd0, rdy, rsp);
    model_prio = 1'b1;
    vectors++;
    if (rdy !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL add_ready got %b exp 01", rdy);
    end
    vectors++;
    if (rsp !== {2'b10, 3'b000, 4'd8}) begin
      miscompares++;
      $display("[TB] FAIL add_rsp got %b exp %b", rsp, {2'b10, 3'b000, 4'd8});
    end
    vectors++;
    if ({rsp_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL add_idle got %b exp 00", {rsp_valid, busy});
    end
  endtask

  task automatic test_wrap_zero();
    logic [1:0] rdy;
    logic [8:0] rsp;
    single_txn(1'b1, 4'd15, 4'd1, 3'd0, rdy, rsp);
    model_prio = 1'b0;
    vectors++;
    if (rdy !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL wrap_ready got %b exp 10", rdy);
    end
    vectors++;
    if (rsp !== {2'b11, 3'b110, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL wrap_rsp got %b exp %b", rsp, {2'b11, 3'b110, 4'd0});
    end
  endtask

  // Both requesters held valid: grants alternate, one accept every 3 cycles.
  task automatic test_contention();
    logic exp_ids[$];
    logic w, eid;
    int last = -1;
    int grants = 0;
    rsp_ready = 1'b1;
    r0_valid = 1'b1; r0_a = 4'd7; r0_b = 4'd3; r0_op = 3'd2;
    r1_valid = 1'b1; r1_a = 4'd7; r1_b = 4'd3; r1_op = 3'd4;
    for (int cyc = 0; cyc < 18; cyc++) begin
      #1;
      if (r0_ready | r1_ready) begin
        w = model_prio;
        vectors++;
        if ({r1_ready, r0_ready} !== (w ? 2'b10 : 2'b01)) begin
          miscompares++;
          $display("[TB] FAIL cont_grant cyc %0d got %b exp %b", cyc,
                   {r1_ready, r0_ready}, (w ? 2'b10 : 2'b01));
        end
        if (last >= 0) begin
          vectors++;
          if (cyc - last !== 3) begin
            miscompares++;
            $display("[TB] FAIL cont_spacing got %0d exp 3", cyc - last);
          end
        end
        last = cyc;
        grants++;
        model_prio = ~w;
        exp_ids.push_back(w);
      end
      if (rsp_valid) begin
        eid = (exp_ids.size() > 0) ? exp_ids.pop_front() : 1'bx;
        vectors++;
        if ({rsp_id, rsp_result} !== {eid, (eid ? 4'd4 : 4'd3)}) begin
          miscompares++;
          $display("[TB] FAIL cont_rsp got id %b res %0d exp id %b", rsp_id, rsp_result, eid);
        end
      end
      @(negedge clk);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    vectors++;
    if (grants !== 6) begin
      miscompares++;
      $display("[TB] FAIL cont_count got %0d exp 6", grants);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    r0_valid = 1'b1; r0_a = 4'd5; r0_b = 4'd3; r0_op = 3'd1;
    @(negedge clk);
    model_prio = 1'b1;
    r1_valid = 1'b1; r1_a = 4'd1; r1_b = 4'd1; r1_op = 3'd0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if ({rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_err, rsp_result, r1_ready, r0_ready}
          !== {2'b10, 3'b100, 4'd2, 2'b00}) begin
        miscompares++;
        $display("[TB] FAIL bp_hold cyc %0d got %b exp %b", i,
                 {rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_err, rsp_result, r1_ready, r0_ready},
                 {2'b10, 3'b100, 4'd2, 2'b00});
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if ({busy, rsp_valid, r1_ready, r0_ready} !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL bp_release got %b exp 0010", {busy, rsp_valid, r1_ready, r0_ready});
    end
    idle_inputs();
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_dropped_valid got busy %b exp 0", busy);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] rdy;
    logic [8:0] rsp;
    single_txn(1'b0, 4'd9, 4'($urandom_range(0, 15)), 3'd7, rdy, rsp);
    model_prio = 1'b1;
    vectors++;
    if (rsp !== {2'b10, 3'b011, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL illegal7 got %b exp %b", rsp, {2'b10, 3'b011, 4'd0});
    end
    single_txn(1'b1, 4'd4, 4'd4, 3'd6, rdy, rsp);
    model_prio = 1'b0;
    vectors++;
    if (rsp !== {2'b11, 3'b011, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL illegal6 got %b exp %b", rsp, {2'b11, 3'b011, 4'd0});
    end
  endtask

  task automatic test_random();
    int v, hold;
    logic w;
    logic [3:0] wa, wb;
    logic [2:0] wop;
    logic [8:0] expv;
    for (int n = 0; n < 40; n++) begin
      rsp_ready = 1'b0;
      v = $urandom_range(1, 3);
      r0_a = 4'($urandom); r0_b = 4'($urandom); r0_op = 3'($urandom);
      r1_a = 4'($urandom); r1_b = 4'($urandom); r1_op = 3'($urandom);
      r0_valid = v[0]; r1_valid = v[1];
      w = (v == 3) ? model_prio : (v == 2);
      wa = w ? r1_a : r0_a; wb = w ? r1_b : r0_b; wop = w ? r1_op : r0_op;
      expv = {2'b1, w, exp_rsp(wa, wb, wop)};
      #1;
      vectors++;
      if ({r1_ready, r0_ready} !== (w ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("[TB] FAIL rnd_grant n %0d got %b exp %b", n, {r1_ready, r0_ready},
                 (w ? 2'b10 : 2'b01));
      end
      model_prio = ~w;
      @(negedge clk);
      r0_valid = 1'b0; r1_valid = 1'b0;
      @(negedge clk);
      hold = $urandom_range(0, 3);
      for (int k = 0; k <= hold; k++) begin
        vectors++;
        if ({rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_err, rsp_result} !== expv) begin
          miscompares++;
          $display("[TB] FAIL rnd_rsp n %0d k %0d got %b exp %b", n, k,
                   {rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_err, rsp_result}, expv);
        end
        if (k == hold) rsp_ready = 1'b1;
        @(negedge clk);
      end
      vectors++;
      if ({rsp_valid, busy} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL rnd_done n %0d got %b exp 00", n, {rsp_valid, busy});
      end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_resp();
    rsp_ready = 1'b0;
    r0_valid = 1'b1; r0_a = 4'd6; r0_b = 4'd6; r0_op = 3'd3;
    @(negedge clk);
    r0_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rmr_pre got rsp_valid %b exp 1", rsp_valid);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({rsp_valid, busy, rsp_id, rsp_carry, rsp_zero, rsp_err, rsp_result} !== 10'b0) begin
      miscompares++;
      $display("[TB] FAIL rmr_async got %b exp 0",
               {rsp_valid, busy, rsp_id, rsp_carry, rsp_zero, rsp_err, rsp_result});
    end
    @(negedge clk);
    rst = 1'b0;
    model_prio = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    vectors++;
    if ({r1_ready, r0_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL rmr_prio got %b exp 01", {r1_ready, r0_ready});
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_add();
    test_wrap_zero();
    test_contention();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_mid_resp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
